// File: rtl/ttl_counter_n.sv
// ttl_counter_n
//   Presettable synchronous counter built from NIBBLES cascaded 4-bit digits.
//   Each digit is binary (0..15) or decade (0..9), selected by BCD. The counter
//   counts up or down and has a synchronous clear, a synchronous load, a
//   combinational terminal-count output and a registered wrap pulse.
//
// Ports
//   clk     in   counter clock; all state changes on the rising edge
//   n_clr   in   asynchronous active-low reset (q=0, wrap=0)
//   n_sclr  in   synchronous active-low clear (highest edge priority)
//   n_load  in   synchronous active-low parallel load of din
//   din     in   [4*NIBBLES-1:0] load data, loaded verbatim
//   enp     in   count enable P
//   ent     in   count enable T; also gates rco
//   up_dn   in   1 = count up, 0 = count down
//   q       out  [4*NIBBLES-1:0] counter value, digit 0 in q[3:0]
//   rco     out  ent & all digits at terminal value (combinational)
//   wrap    out  one-cycle pulse following an edge on which the counter wrapped
module ttl_counter_n #(
    parameter int unsigned NIBBLES = 1,
    parameter bit          BCD     = 1'b0
) (
    input  logic                   clk,
    input  logic                   n_clr,
    input  logic                   n_sclr,
    input  logic                   n_load,
    input  logic [4*NIBBLES-1:0]   din,
    input  logic                   enp,
    input  logic                   ent,
    input  logic                   up_dn,
    output logic [4*NIBBLES-1:0]   q,
    output logic                   rco,
    output logic                   wrap
);

    localparam int unsigned W   = 4 * NIBBLES;
    localparam logic [3:0]  TOP = BCD ? 4'd9 : 4'd15;

    logic [W-1:0]       r_q;
    logic               r_wrap;
    logic [W-1:0]       w_q_next;
    logic [NIBBLES-1:0] w_term;
    logic               w_count;
    logic               w_all_term;
    logic               w_carry;

    // One step of a single digit. Invalid decade digits jump straight to the
    // wrap target of the current direction.
    function automatic logic [3:0] digit_step(input logic [3:0] d, input logic up);
        if (BCD && (d > 4'd9)) begin
            return up ? 4'd0 : 4'd9;
        end
        if (up) begin
            return (d == TOP) ? 4'd0 : d + 4'd1;
        end
        return (d == 4'd0) ? TOP : d - 4'd1;
    endfunction

    // Terminal value per digit. An invalid decade digit never matches either
    // terminal value, so it can never propagate a carry or borrow.
    always_comb begin
        w_term = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            w_term[i] = up_dn ? (r_q[4*i +: 4] == TOP) : (r_q[4*i +: 4] == 4'd0);
        end
    end

    assign w_count    = enp & ent;
    assign w_all_term = &w_term;

    // Ripple enable: a digit steps only when every digit below it is terminal.
    always_comb begin
        w_q_next = r_q;
        w_carry  = w_count;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (w_carry) begin
                w_q_next[4*i +: 4] = digit_step(r_q[4*i +: 4], up_dn);
            end
            w_carry = w_carry & w_term[i];
        end
    end

    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else if (!n_sclr) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else if (!n_load) begin
            r_q    <= din;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_count & w_all_term;
        end
    end

    assign q    = r_q;
    assign rco  = ent & w_all_term;
    assign wrap = r_wrap;

endmodule

// File: doc/ttl_counter_n.md
Name: ttl_counter_n

Overview:
- Parametrised synchronous presettable counter. Successor to the single-nibble 4-bit counter primitive.
- Generalised to N cascaded nibbles, binary or BCD (decade) digits, up/down direction, synchronous clear and a registered wrap flag.
- Used in arcade video/timing chains where LS160/161/162/163/190/191-style counters were chained on the original PCB.

Parameters:
- NIBBLES, 1, number of 4-bit digits; counter width W = 4*NIBBLES.
- BCD, 0, 0 = binary digits (0..15); 1 = decade digits (0..9).

Ports:
- clk  input  1  counter clock, all state changes on rising edge.
- n_clr  input  1  reset, asynchronous, active-low; forces q=0, wrap=0.
- n_sclr  input  1  synchronous clear, active-low (LS163-style).
- n_load  input  1  synchronous parallel load, active-low.
- din  input  W  parallel load data.
- enp  input  1  count enable P.
- ent  input  1  count enable T; also gates rco.
- up_dn  input  1  1 = count up, 0 = count down.
- q  output  W  counter value, digit 0 in q[3:0].
- rco  output  1  combinational terminal count, for cascading.
- wrap  output  1  registered one-cycle pulse after a wrap-around.

Behaviour:
- Reset: n_clr low -> q=0, wrap=0 immediately, regardless of clk. Release is synchronous to the next clk edge; no count occurs on an edge while n_clr is low.
- Priority at each clk rising edge, highest first:
  - n_sclr=0 -> q=0.
  - else n_load=0 -> q=din, loaded verbatim; invalid BCD digits are accepted.
  - else enp&ent=1 -> count one step in the up_dn direction.
  - else hold.
- Digit terminal value: up = 15 (binary) or 9 (BCD); down = 0.
- Digit i steps only when count is enabled and every digit below i sits at its terminal value for the current direction. Digit 0 steps whenever count is enabled.
- Binary digit step: +1 or -1 mod 16.
- BCD digit step, valid digits: up 9->0, down 0->9, otherwise +/-1.
- BCD digit step, invalid digits (10..15):
  - up -> 0; down -> 9.
  - An invalid digit is never terminal, so it produces no carry or borrow into higher digits.
- Result: binary full-range wrap is 2^W-1 <-> 0; BCD wrap is 10^N-1 <-> 0.
- rco = ent & (every digit at its terminal value for the current up_dn).
  - Purely combinational; it responds to up_dn and ent changes without a clock.
  - Independent of enp, n_load and n_sclr.
- wrap register:
  - Set to 1 on a clk edge where a count step occurred and all digits were at terminal value (i.e. the counter wrapped).
  - Cleared to 0 on every other edge, including load and sclr edges.
  - Goes high one cycle after the wrapping edge, for exactly one cycle per wrap. Consecutive wraps (e.g. NIBBLES=1, alternating up_dn) give consecutive pulses.
- Direction change takes effect on the next enabled edge. No extra latency and no glitch on q.
- Load and count on the same edge: load wins, no count, wrap=0.
- n_clr asserted mid-count: q and wrap go to 0 asynchronously. The first enabled edge after release counts from 0.

Test Plan:
- NIBBLES=2, BCD=0, up, enp=ent=1 from reset for 256 clocks:
  - q steps 0x00..0xFF then 0x00.
  - rco=1 only while q=0xFF.
  - wrap=1 exactly on the cycle after the 0xFF->0x00 edge.
- NIBBLES=2, BCD=1:
  - Load 0x98, count up: 0x99 (rco=1), then 0x00, wrap pulse.
  - Switch up_dn=0 at 0x00: rco=1 immediately; next edge -> 0x99, wrap pulse.
- NIBBLES=2, BCD=1, load 0x1C, count up -> 0x10 (no carry). Load 0x1C, count down -> 0x19.
- Priority, same edge:
  - n_sclr=0, n_load=0, enp=ent=1 -> q=0.
  - n_load=0 with din=0x5A, enp=ent=1 -> q=0x5A, not 0x5B.
  - enp=1, ent=0 -> hold; rco=0 even at 0xFF.
- Async reset: count to 0x37, pulse n_clr low between edges -> q=0 before the next edge, wrap=0. First edge after release -> 0x01.
- NIBBLES=1, BCD=0, up_dn toggling each cycle starting at 0xF:
  - q sequence F->0->F->0.
  - wrap high on every cycle after the first wrapping edge.
